// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter onto a single-ported RAM controller
// Dcache wins by default; a saturating streak counter forces an icache grant.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err,
  output logic [2:0]        d_streak
);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [2:0] MAX_S     = 3'(MAX_D_STREAK);

  state_t state, next;
  logic   dreq;

  assign dreq  = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      d_streak <= 3'd0;
      mem_err  <= 1'b0;
    end else begin
      state <= next;
      // Streak only moves when a new grant is issued
      if (state == IDLE) begin
        if (next == D_ACC) begin
          if (!iREN)
            d_streak <= 3'd0;
          else if (d_streak != MAX_S)
            d_streak <= d_streak + 3'd1;
        end else if (next == I_ACC) begin
          d_streak <= 3'd0;
        end
      end
      if (state != IDLE && ramstate == RS_ERROR)
        mem_err <= 1'b1;
    end
  end

  always_comb begin
    next     = state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state)
      IDLE: begin
        if (dreq && (!iREN || d_streak != MAX_S))
          next = D_ACC;
        else if (iREN)
          next = I_ACC;
      end
      I_ACC: begin
        if (!iREN) begin
          next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == RS_ACCESS) begin
            iwait = 1'b0;
            next  = IDLE;
          end
        end
      end
      D_ACC: begin
        if (!dreq) begin
          next = IDLE;
        end else begin
          // Write takes precedence when both enables are high
          ramWEN   = dWEN;
          ramREN   = !dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ramstate == RS_ACCESS) begin
            dwait = 1'b0;
            next  = IDLE;
          end
        end
      end
      default: next = IDLE;
    endcase
  end

endmodule
